// File: rtl/router_pkg.sv
// Shared types and helpers for the 2x2 mesh corner router: corner orientation,
// port indices, header bit positions and the dimension-free route decision.
package router_pkg;

    typedef enum logic [1:0] {
        CORNERSW,
        CORNERSE,
        CORNERNW,
        CORNERNE
    } router_type_e;

    typedef enum logic [1:0] {
        PROC,
        P1,
        P2,
        P3
    } port_e;

    localparam int unsigned NPORTS    = 4;
    // Offsets from the MSB: destination x at data[n-1], destination y at data[n-2]
    localparam int unsigned HDR_X_OFS = 1;
    localparam int unsigned HDR_Y_OFS = 2;

    function automatic logic corner_x(input router_type_e t);
        return (t == CORNERSE) || (t == CORNERNE);
    endfunction

    function automatic logic corner_y(input router_type_e t);
        return (t == CORNERNW) || (t == CORNERNE);
    endfunction

    function automatic port_e route(input logic dx, input logic dy,
                                    input logic sx, input logic sy);
        if (dx != sx && dy != sy) return P3;
        if (dx != sx)             return P1;
        if (dy != sy)             return P2;
        return PROC;
    endfunction

    function automatic logic [NPORTS-1:0] port_onehot(input port_e p);
        logic [NPORTS-1:0] oh;
        oh = '0;
        oh[p] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rt_port.sv
// Two-phase (toggle) req/ack link carrying one flit per transfer.
interface RTPort #(
    parameter int N = 32
);
    logic         req;
    logic         ack;
    logic [N-1:0] data;

    modport Input  (input  req, input  data, output ack);
    modport Output (output req, output data, input  ack);
endinterface

// File: rtl/rt_out_arbiter.sv
// Round-robin arbiter for one router output: one-hot grant, search starts just
// after the last granted input; pointer resets to PROC so P1 is searched first.
module rt_out_arbiter
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req_i,
    output logic [NPORTS-1:0] gnt_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PROC;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/corner_router.sv
// Four-port corner switch of the 2x2 mesh: one-word buffer per input, routing
// decided at capture, round-robin arbitration per output, 2-phase handshakes.
module corner_router
    import router_pkg::*;
#(
    parameter router_type_e rtype = CORNERSW,
    parameter int           n     = 32,
    parameter int           srcx  = 0,
    parameter int           srcy  = 0,
    parameter int           maxx  = 1,
    parameter int           maxy  = 1
) (
    input logic   clk,
    input logic   rst,
    RTPort.Input  proc_input,
    RTPort.Output proc_output,
    RTPort.Input  port1_input,
    RTPort.Output port1_output,
    RTPort.Input  port2_input,
    RTPort.Output port2_output,
    RTPort.Input  port3_input,
    RTPort.Output port3_output
);

    if (n < 8 || maxx != 1 || maxy != 1 ||
        srcx != int'(corner_x(rtype)) || srcy != int'(corner_y(rtype))) begin : g_param_err
        $error("corner_router: unsupported parameters or rtype/srcx/srcy mismatch");
    end

    localparam logic SX = srcx[0];
    localparam logic SY = srcy[0];

    logic [NPORTS-1:0] in_req;
    logic [NPORTS-1:0] out_ack;
    logic [NPORTS-1:0] in_ack_q;
    logic [NPORTS-1:0] out_req_q;
    logic [NPORTS-1:0] buf_vld_q;
    logic [NPORTS-1:0] busy;
    logic [NPORTS-1:0] granted;
    logic [n-1:0]      in_data    [NPORTS];
    logic [n-1:0]      buf_data_q [NPORTS];
    logic [NPORTS-1:0] buf_dst_q  [NPORTS];
    logic [NPORTS-1:0] cap_dst    [NPORTS];
    logic [n-1:0]      out_data_q [NPORTS];
    logic [n-1:0]      out_data_d [NPORTS];
    logic [NPORTS-1:0] arb_req    [NPORTS];
    logic [NPORTS-1:0] gnt        [NPORTS];

    assign in_req[PROC] = proc_input.req;
    assign in_req[P1]   = port1_input.req;
    assign in_req[P2]   = port2_input.req;
    assign in_req[P3]   = port3_input.req;
    assign in_data[PROC] = proc_input.data;
    assign in_data[P1]   = port1_input.data;
    assign in_data[P2]   = port2_input.data;
    assign in_data[P3]   = port3_input.data;
    assign proc_input.ack  = in_ack_q[PROC];
    assign port1_input.ack = in_ack_q[P1];
    assign port2_input.ack = in_ack_q[P2];
    assign port3_input.ack = in_ack_q[P3];

    assign out_ack[PROC] = proc_output.ack;
    assign out_ack[P1]   = port1_output.ack;
    assign out_ack[P2]   = port2_output.ack;
    assign out_ack[P3]   = port3_output.ack;
    assign proc_output.req   = out_req_q[PROC];
    assign port1_output.req  = out_req_q[P1];
    assign port2_output.req  = out_req_q[P2];
    assign port3_output.req  = out_req_q[P3];
    assign proc_output.data  = out_data_q[PROC];
    assign port1_output.data = out_data_q[P1];
    assign port2_output.data = out_data_q[P2];
    assign port3_output.data = out_data_q[P3];

    // Each buffer targets exactly one output, so an input can win at most once per cycle
    always_comb begin
        granted = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            busy[o]       = out_req_q[o] ^ out_ack[o];
            out_data_d[o] = '0;
            cap_dst[o]    = port_onehot(route(in_data[o][n-HDR_X_OFS],
                                              in_data[o][n-HDR_Y_OFS], SX, SY));
        end
        for (int unsigned o = 0; o < NPORTS; o++) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                arb_req[o][i] = buf_vld_q[i] & buf_dst_q[i][o] & ~busy[o];
                granted[i]    = granted[i] | gnt[o][i];
                if (gnt[o][i]) begin
                    out_data_d[o] = buf_data_q[i];
                end
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rt_out_arbiter u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (arb_req[o]),
            .gnt_o (gnt[o])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ack_q  <= '0;
            out_req_q <= '0;
            buf_vld_q <= '0;
            for (int unsigned i = 0; i < NPORTS; i++) begin
                buf_data_q[i] <= '0;
                buf_dst_q[i]  <= '0;
                out_data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                // A buffer drained this edge refills no earlier than the next one
                if (granted[i]) begin
                    buf_vld_q[i] <= 1'b0;
                end else if (!buf_vld_q[i] && (in_req[i] != in_ack_q[i])) begin
                    buf_vld_q[i]  <= 1'b1;
                    buf_data_q[i] <= in_data[i];
                    buf_dst_q[i]  <= cap_dst[i];
                    in_ack_q[i]   <= ~in_ack_q[i];
                end
            end
            for (int unsigned o = 0; o < NPORTS; o++) begin
                if (|gnt[o]) begin
                    out_data_q[o] <= out_data_d[o];
                    out_req_q[o]  <= ~out_req_q[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_corner_router.sv
// Directed bench for corner_router at the SW corner (srcx=srcy=0).
module tb_corner_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        exp_ack;
    logic        exp_req;
    logic [32:0] smp;
    logic [31:0] t2_word [4] = '{32'h8FFFFFFF, 32'h4FFFFFFF, 32'hCFFFFFFF, 32'h0FFFFFFF};
    logic [31:0] t4_word [3] = '{32'h2EEEEEEE, 32'h1DDDDDDD, 32'h1CCCCCCC};

    RTPort #(.N(32)) pi  ();
    RTPort #(.N(32)) po  ();
    RTPort #(.N(32)) p1i ();
    RTPort #(.N(32)) p1o ();
    RTPort #(.N(32)) p2i ();
    RTPort #(.N(32)) p2o ();
    RTPort #(.N(32)) p3i ();
    RTPort #(.N(32)) p3o ();

    corner_router #(.n(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .proc_input   (pi),
        .proc_output  (po),
        .port1_input  (p1i),
        .port1_output (p1o),
        .port2_input  (p2i),
        .port2_output (p2o),
        .port3_input  (p3i),
        .port3_output (p3o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic zero_drives();
        pi.req  = 1'b0; pi.data  = '0;
        p1i.req = 1'b0; p1i.data = '0;
        p2i.req = 1'b0; p2i.data = '0;
        p3i.req = 1'b0; p3i.data = '0;
        po.ack  = 1'b0;
        p1o.ack = 1'b0;
        p2o.ack = 1'b0;
        p3o.ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acks"}, 32'({pi.ack, p1i.ack, p2i.ack, p3i.ack}), 32'h0);
        check({tag, "_reqs"}, 32'({po.req, p1o.req, p2o.req, p3o.req}), 32'h0);
        check({tag, "_pdata"}, po.data, 32'h0);
        check({tag, "_1data"}, p1o.data, 32'h0);
        check({tag, "_2data"}, p2o.data, 32'h0);
        check({tag, "_3data"}, p3o.data, 32'h0);
    endtask

    // Index 0..3 selects port1, port2, port3, proc output as {req, data}
    function automatic logic [32:0] out_port(input int unsigned idx);
        case (idx)
            0:       return {p1o.req, p1o.data};
            1:       return {p2o.req, p2o.data};
            2:       return {p3o.req, p3o.data};
            default: return {po.req, po.data};
        endcase
    endfunction

    initial begin
        zero_drives();
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Processor routing to each output
        exp_ack = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            pi.data = t2_word[i];
            pi.req  = ~pi.req;
            exp_ack = ~exp_ack;
            tick();
            check($sformatf("route%0d_ack", i), pi.ack, exp_ack);
            smp = out_port(i);
            check($sformatf("route%0d_req_early", i), smp[32], 1'b0);
            tick();
            smp = out_port(i);
            check($sformatf("route%0d_req", i), smp[32], 1'b1);
            check($sformatf("route%0d_data", i), smp[31:0], t2_word[i]);
        end

        // Neighbour to processor
        po.ack  = 1'b1;
        p1o.ack = 1'b1;
        p2o.ack = 1'b1;
        p3o.ack = 1'b1;
        p1i.data = 32'h2EEEEEEE;
        p1i.req  = 1'b1;
        tick();
        check("nb_ack", p1i.ack, 1'b1);
        check("nb_req_early", po.req, 1'b1);
        tick();
        check("nb_req", po.req, 1'b0);
        check("nb_data", po.data, 32'h2EEEEEEE);

        // Contention from fresh reset: P1, P2, P3 order
        rst = 1'b1;
        zero_drives();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        p1i.data = t4_word[0]; p1i.req = 1'b1;
        p2i.data = t4_word[1]; p2i.req = 1'b1;
        p3i.data = t4_word[2]; p3i.req = 1'b1;
        tick();
        check("cont_acks", 32'({p1i.ack, p2i.ack, p3i.ack}), 32'h7);
        check("cont_req_early", po.req, 1'b0);
        exp_req = 1'b0;
        for (int unsigned w = 0; w < 3; w++) begin
            exp_req = ~exp_req;
            tick();
            check($sformatf("cont%0d_req", w), po.req, exp_req);
            check($sformatf("cont%0d_data", w), po.data, t4_word[w]);
            tick();
            check($sformatf("cont%0d_hold", w), po.data, t4_word[w]);
            po.ack = exp_req;
        end

        // Backpressure: output free (req=ack=1), port1 req=ack=1
        p1i.data = 32'h2EEEEEEE; p1i.req = 1'b0;
        tick();
        check("bp_ack1", p1i.ack, 1'b0);
        p1i.data = 32'h2AAAAAAA; p1i.req = 1'b1;
        tick();
        check("bp_out1_req", po.req, 1'b0);
        check("bp_out1_data", po.data, 32'h2EEEEEEE);
        tick();
        check("bp_ack2", p1i.ack, 1'b1);
        p1i.data = 32'h2BBBBBBB; p1i.req = 1'b0;
        repeat (3) tick();
        check("bp_ack3_held", p1i.ack, 1'b1);
        check("bp_out_held_req", po.req, 1'b0);
        check("bp_out_held_data", po.data, 32'h2EEEEEEE);
        po.ack = 1'b0;
        tick();
        check("bp_out2_req", po.req, 1'b1);
        check("bp_out2_data", po.data, 32'h2AAAAAAA);
        check("bp_ack3_wait", p1i.ack, 1'b1);
        po.ack = 1'b1;
        tick();
        check("bp_ack3", p1i.ack, 1'b0);
        check("bp_out3_early", po.req, 1'b1);
        tick();
        check("bp_out3_req", po.req, 1'b0);
        check("bp_out3_data", po.data, 32'h2BBBBBBB);

        // Reset mid-operation: proc output busy (req=0, ack=1), port1 buffer full
        p1i.data = 32'h2EEEEEEE; p1i.req = 1'b1;
        repeat (2) tick();
        check("mid_ack_pre", p1i.ack, 1'b1);
        check("mid_req_pre", po.req, 1'b0);
        rst = 1'b1;
        zero_drives();
        tick();
        check_all_zero("mid_rst");
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("post_idle", po.req, 1'b0);
        pi.data = 32'h8FFFFFFF; pi.req = 1'b1;
        tick();
        check("post_ack", pi.ack, 1'b1);
        tick();
        check("post_req", p1o.req, 1'b1);
        check("post_data", p1o.data, 32'h8FFFFFFF);
        check("post_proc_quiet", po.req, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
